// File: rtl/fp_mult_pkg.sv
// Shared constants and FSM state type for the single-precision mantissa multiply path.
package fp_mult_pkg;

    localparam int MANT_W = 24;
    localparam int PROD_W = 2 * MANT_W;
    localparam int CNT_W  = $clog2(MANT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/mant_norm.sv
// Normalizes a raw 48-bit significand product: drops the hidden bit, flags a product >= 2.0.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module mant_norm
    import fp_mult_pkg::*;
(
    input  logic [PROD_W-1:0] raw,
    output logic [PROD_W-1:0] product,
    output logic              exp_inc
);

    // Shifting left keeps every low bit, so the downstream sticky OR stays exact.
    always_comb begin
        if (raw[PROD_W-1]) begin
            product = {raw[PROD_W-2:0], 1'b0};
            exp_inc = 1'b1;
        end else begin
            product = {raw[PROD_W-3:0], 2'b00};
            exp_inc = 1'b0;
        end
    end

endmodule

// File: rtl/mant_mult_seq.sv
// Sequential 24x24 shift-add significand multiplier with normalization, one multiplier bit per cycle.
// Latency: result valid 25 cycles after accept (1 cycle for a zero operand when MANT_MULT_EARLY_ZERO_EN is defined).
// Backpressure: result held in DONE until out_ready_i; no new operands accepted meanwhile.
module mant_mult_seq
    import fp_mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [MANT_W-1:0] a_i,
    input  logic [MANT_W-1:0] b_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [PROD_W-1:0] product_o,
    output logic              exp_inc_o
);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] a_sh;
    logic [MANT_W-1:0] b_sh;
    logic [PROD_W-1:0] acc;
    logic [PROD_W-1:0] norm_prod;
    logic              norm_inc;
    logic              accept;
    logic              zero_skip;

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);
    assign accept      = in_valid_i & in_ready_o;

`ifdef MANT_MULT_EARLY_ZERO_EN
    assign zero_skip = (a_i == '0) || (b_i == '0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_skip ? NORM : MUL;
            MUL:     if (cnt == CNT_W'(MANT_W - 1)) state_nxt = NORM;
            NORM:    state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    mant_norm u_norm (
        .raw     (acc),
        .product (norm_prod),
        .exp_inc (norm_inc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            acc       <= '0;
            product_o <= '0;
            exp_inc_o <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh <= {{MANT_W{1'b0}}, a_i};
                        b_sh <= b_i;
                        acc  <= '0;
                        cnt  <= '0;
                    end
                end
                // a_sh holds A*2^cnt; b_sh[0] is multiplier bit cnt.
                MUL: begin
                    if (b_sh[0]) acc <= acc + a_sh;
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh >> 1;
                    cnt  <= cnt + 1'b1;
                end
                NORM: begin
                    product_o <= norm_prod;
                    exp_inc_o <= norm_inc;
                end
                default: ;
            endcase
        end
    end

endmodule
